pll_profile_sequencer: RTL and testbench



---
 rtl/pll_profile_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_pll_profile_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_profile_sequencer.sv
// pll_profile_sequencer: programs a Cyclone V PLL reconfig core over Avalon-MM with one of
// NUM_PROFILES stored M/N/C profiles, then waits for a stable lock before reporting done.
// Optional feature: define PLL_SEQ_LOCK_TIMEOUT_EN to bound the lock wait by LOCK_TIMEOUT cycles.
module pll_profile_sequencer #(
  parameter int unsigned NUM_PROFILES = 4,
  parameter int unsigned NUM_CNT      = 2,
  parameter int unsigned LOCK_STABLE  = 4,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  localparam int unsigned SelW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req,
  input  logic [SelW-1:0]                   sel,
  input  logic [NUM_PROFILES*18-1:0]         prof_n,
  input  logic [NUM_PROFILES*18-1:0]         prof_m,
  input  logic [NUM_PROFILES*NUM_CNT*18-1:0] prof_c,
  input  logic                              pll_locked,
  input  logic                              mgmt_waitrequest,
  output logic [5:0]                        mgmt_address,
  output logic                              mgmt_write,
  output logic [31:0]                       mgmt_writedata,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [SelW-1:0]                   cur_profile
);

  // Elaboration-time parameter range checks.
  if (NUM_PROFILES < 1 || NUM_PROFILES > 16) begin : g_bad_profiles
    $error("NUM_PROFILES must be 1..16");
  end
  if (NUM_CNT < 1 || NUM_CNT > 18) begin : g_bad_cnt
    $error("NUM_CNT must be 1..18");
  end
  if (LOCK_STABLE < 1) begin : g_bad_stable
    $error("LOCK_STABLE must be at least 1");
  end
  if (LOCK_TIMEOUT < 1) begin : g_bad_timeout
    $error("LOCK_TIMEOUT must be at least 1");
  end

  localparam int unsigned LckW = $clog2(LOCK_STABLE + 1);
  localparam logic [LckW-1:0] LockLast = LckW'(LOCK_STABLE - 1);
  localparam logic [4:0] CntLast = 5'(NUM_CNT - 1);

  typedef enum logic [2:0] {
    StIdle, StWrMode, StWrN, StWrM, StWrC, StWrStart, StLockWait, StFin
  } state_e;

  state_e                 state_q, state_d;
  logic [SelW-1:0]        sel_q, sel_d;
  logic [SelW-1:0]        cur_q, cur_d;
  logic [17:0]            n_q, n_d;
  logic [17:0]            m_q, m_d;
  logic [NUM_CNT*18-1:0]  c_q, c_d;
  logic [4:0]             k_q, k_d;
  logic [LckW-1:0]        lock_cnt_q, lock_cnt_d;
  logic                   err_q, err_d;
  logic [1:0]             sync_q;
  logic                   locked_s;
  logic                   sel_bad;
  logic [17:0]            c_word;

`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(LOCK_TIMEOUT - 1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
`endif

  assign locked_s    = sync_q[1];
  assign sel_bad     = 32'(sel) >= NUM_PROFILES;
  assign c_word      = c_q[18*k_q +: 18];
  assign err         = err_q;
  assign cur_profile = cur_q;

  // Two-flop synchroniser for the asynchronous PLL lock signal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  // Sequencer state and latched profile registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      cur_q      <= '0;
      n_q        <= '0;
      m_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      lock_cnt_q <= '0;
      err_q      <= 1'b0;
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cur_q      <= cur_d;
      n_q        <= n_d;
      m_q        <= m_d;
      c_q        <= c_d;
      k_q        <= k_d;
      lock_cnt_q <= lock_cnt_d;
      err_q      <= err_d;
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  // Next-state logic and Avalon-MM write outputs.
  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    cur_d          = cur_q;
    n_d            = n_q;
    m_d            = m_q;
    c_d            = c_q;
    k_d            = k_q;
    lock_cnt_d     = lock_cnt_q;
    err_d          = err_q;
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
    to_cnt_d       = to_cnt_q;
`endif
    mgmt_write     = 1'b0;
    mgmt_address   = 6'h00;
    mgmt_writedata = 32'h0;
    busy           = (state_q != StIdle);
    done           = (state_q == StFin);

    unique case (state_q)
      StIdle: begin
        if (req) begin
          sel_d = sel;
          err_d = 1'b0;
          if (sel_bad) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            // Snapshot the profile so later input changes cannot disturb the sequence.
            n_d     = prof_n[18*sel +: 18];
            m_d     = prof_m[18*sel +: 18];
            c_d     = prof_c[NUM_CNT*18*sel +: NUM_CNT*18];
            state_d = StWrMode;
          end
        end
      end
      StWrMode: begin
        mgmt_write   = 1'b1;
        mgmt_address = 6'h00;
        if (!mgmt_waitrequest) state_d = StWrN;
      end
      StWrN: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h03;
        mgmt_writedata = {14'h0, n_q};
        if (!mgmt_waitrequest) state_d = StWrM;
      end
      StWrM: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h04;
        mgmt_writedata = {14'h0, m_q};
        if (!mgmt_waitrequest) begin
          k_d     = 5'd0;
          state_d = StWrC;
        end
      end
      StWrC: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h05;
        mgmt_writedata = {9'h0, k_q, c_word};
        if (!mgmt_waitrequest) begin
          if (k_q == CntLast) begin
            k_d     = 5'd0;
            state_d = StWrStart;
          end else begin
            k_d = k_q + 5'd1;
          end
        end
      end
      StWrStart: begin
        mgmt_write   = 1'b1;
        mgmt_address = 6'h02;
        if (!mgmt_waitrequest) begin
          // Lock is only trusted once counted after start, even if already high.
          lock_cnt_d = '0;
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
          state_d    = StLockWait;
        end
      end
      StLockWait: begin
        if (locked_s && lock_cnt_q == LockLast) begin
          cur_d   = sel_q;
          state_d = StFin;
        end else begin
          lock_cnt_d = locked_s ? lock_cnt_q + 1'b1 : '0;
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
          if (to_cnt_q == ToLast) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
`endif
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_profile_sequencer.sv
// Bench for pll_profile_sequencer: table of requests plus hand-written reset and lock-wait
// sequences; a scoreboard queue holds the expected Avalon-MM writes per accepted request.
module tb_pll_profile_sequencer;

  localparam int NP = 5;
  localparam int NC = 2;
  localparam int LS = 4;
  localparam int LT = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic [2:0]        sel = 3'd0;
  logic [NP*18-1:0]  prof_n;
  logic [NP*18-1:0]  prof_m;
  logic [NP*NC*18-1:0] prof_c;
  logic              pll_locked = 1'b1;
  logic              mgmt_waitrequest = 1'b0;
  logic [5:0]        mgmt_address;
  logic              mgmt_write;
  logic [31:0]       mgmt_writedata;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        cur_profile;

  logic [17:0] pn [NP];
  logic [17:0] pm [NP];
  logic [17:0] pc [NP][NC];
  logic [37:0] sbq [$];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] sel;
    int         stall;     // waitrequest cycles applied on the M write
    logic       toggle;    // drive the 1,1,0,1,1,1,1 lock pattern
    logic       poke;      // raise req while busy
    int         exp_done;  // cycle of the done pulse after acceptance edge
    logic       exp_err;
    logic [2:0] exp_cur;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  pll_profile_sequencer #(
    .NUM_PROFILES (NP),
    .NUM_CNT      (NC),
    .LOCK_STABLE  (LS),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .sel              (sel),
    .prof_n           (prof_n),
    .prof_m           (prof_m),
    .prof_c           (prof_c),
    .pll_locked       (pll_locked),
    .mgmt_waitrequest (mgmt_waitrequest),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .cur_profile      (cur_profile)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int s);
    sbq.push_back({6'h00, 32'h0});
    sbq.push_back({6'h03, 14'h0, pn[s]});
    sbq.push_back({6'h04, 14'h0, pm[s]});
    for (int k = 0; k < NC; k++) sbq.push_back({6'h05, 9'h0, 5'(k), pc[s][k]});
    sbq.push_back({6'h02, 32'h0});
  endtask

  task automatic load_prof();
    for (int p = 0; p < NP; p++) begin
      prof_n[18*p +: 18] = pn[p];
      prof_m[18*p +: 18] = pm[p];
      for (int k = 0; k < NC; k++) prof_c[18*(p*NC+k) +: 18] = pc[p][k];
    end
  endtask

  // Scoreboard: every completed write is compared with the next expected one.
  always begin
    @(negedge clk);
    #2;
    if (mgmt_write && !mgmt_waitrequest && !rst) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr %0h data %0h with nothing expected",
                 mgmt_address, mgmt_writedata);
      end else begin
        chk("write", {mgmt_address, mgmt_writedata}, sbq.pop_front());
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int          c      = 0;
    int          done_c = -1;
    int          stall  = v.stall;
    logic        err_at = 1'b0;
    logic        pw     = 1'b0;
    logic [37:0] pv     = '0;
    logic        pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    if (v.sel < NP) push_exp(int'(v.sel));
    @(negedge clk);
    req = 1'b1;
    sel = v.sel;
    @(posedge clk);
    while (done_c < 0 && c < 60) begin
      @(negedge clk);
      c++;
      if (done) begin
        done_c = c;
        err_at = err;
      end
      if (pw) chk("hold_stable", {mgmt_address, mgmt_writedata}, pv);
      if (c == 1) begin
        chk("busy_on_accept", busy, 1'b1);
        chk("write_on_accept", mgmt_write, !v.exp_err);
        sel    = 3'($urandom);
        prof_n = ~prof_n;
        prof_m = ~prof_m;
        prof_c = ~prof_c;
      end
      req = v.poke && c >= 3 && c <= 5;
      if (req) sel = 3'd1;
      pll_locked = (v.toggle && c >= 5 && c <= 11) ? pat[c-5] : 1'b1;
      mgmt_waitrequest = mgmt_write && mgmt_address == 6'h04 && stall > 0;
      if (mgmt_waitrequest) stall--;
      pw = mgmt_write && mgmt_waitrequest;
      pv = {mgmt_address, mgmt_writedata};
    end
    chk("done_cycle", done_c, v.exp_done);
    chk("err_at_done", err_at, v.exp_err);
    @(negedge clk);
    chk("busy_after_done", busy, 1'b0);
    chk("done_one_cycle", done, 1'b0);
    chk("cur_profile", cur_profile, v.exp_cur);
    @(negedge clk);
    chk("idle_no_write", mgmt_write, 1'b0);
    chk("writes_all_seen", sbq.size(), 0);
    load_prof();
  endtask

  task automatic reset_mid_seq();
    push_exp(3);
    @(negedge clk);
    req = 1'b1;
    sel = 3'd3;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_in_wr_c", mgmt_address, 6'h05);
    #1 rst = 1'b1;
    #1;
    chk("rst_write", mgmt_write, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", mgmt_address, 6'h00);
    chk("rst_data", mgmt_writedata, 32'h0);
    chk("rst_cur", cur_profile, 3'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic lock_test();
    int   c      = 0;
    int   done_c = -1;
    logic err_at = 1'b0;
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    push_exp(2);
    req = 1'b1;
    sel = 3'd2;
    @(posedge clk);
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
    while (done_c < 0 && c < 150) begin
      @(negedge clk);
      c++;
      if (done) begin
        done_c = c;
        err_at = err;
      end
      req = (c == 20);
      sel = 3'd3;
    end
    chk("timeout_done_cycle", done_c, 7 + LT);
    chk("timeout_err", err_at, 1'b1);
    @(negedge clk);
    chk("timeout_busy_low", busy, 1'b0);
    chk("timeout_cur_kept", cur_profile, 3'd1);
`else
    while (c < 150) begin
      @(negedge clk);
      c++;
      if (done && done_c < 0) done_c = c;
      req = (c == 20);
      sel = 3'd3;
    end
    chk("no_lock_no_done", done_c, -1);
    chk("no_lock_still_busy", busy, 1'b1);
    pll_locked = 1'b1;
    while (done_c < 0 && c < 200) begin
      @(negedge clk);
      c++;
      if (done) begin
        done_c = c;
        err_at = err;
      end
    end
    // Lock driven in cycle 150 reaches the FSM in 152; four stable samples end in 155.
    chk("late_lock_done_cycle", done_c, 156);
    chk("late_lock_err", err_at, 1'b0);
    @(negedge clk);
    chk("late_lock_cur", cur_profile, 3'd2);
`endif
    chk("lock_writes_all_seen", sbq.size(), 0);
    pll_locked = 1'b1;
    req = 1'b0;
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      pn[p] = 18'(32'h11111 * (p + 1) ^ 32'h2A5);
      pm[p] = 18'(32'h0F0F3 + p * 32'h1357);
      for (int k = 0; k < NC; k++) pc[p][k] = 18'(32'h20000 | (p * 32'h101 + k * 32'h808 + 32'h33));
    end
    load_prof();

    //          sel   stall tog   poke  done err   cur
    vecs[0] = '{3'd2, 0,    1'b0, 1'b0, 11,  1'b0, 3'd2};
    vecs[1] = '{3'd4, 3,    1'b0, 1'b0, 14,  1'b0, 3'd4};
    vecs[2] = '{3'd5, 0,    1'b0, 1'b0, 1,   1'b1, 3'd4};
    vecs[3] = '{3'd0, 0,    1'b0, 1'b1, 11,  1'b0, 3'd0};
    vecs[4] = '{3'd3, 0,    1'b1, 1'b0, 14,  1'b0, 3'd3};
    vecs[5] = '{3'd7, 0,    1'b0, 1'b0, 1,   1'b1, 3'd3};
    vecs[6] = '{3'd1, 2,    1'b1, 1'b0, 14,  1'b0, 3'd1};

    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_write", mgmt_write, 1'b0);
    chk("reset_addr", mgmt_address, 6'h00);
    chk("reset_data", mgmt_writedata, 32'h0);
    chk("reset_cur", cur_profile, 3'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    reset_mid_seq();
    run_vec('{3'd1, 0, 1'b0, 1'b0, 11, 1'b0, 3'd1});

    lock_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
